// File: rtl/lfsr_range_gen.sv
// Seedable XNOR LFSR (WIDTH 3..16) with lock-up recovery and a req/valid modulo-RANGE reducer.
// Define LFSR_PERIOD_CNT_EN to add the period_cnt / period_wrap outputs.
module lfsr_range_gen #(
    parameter int WIDTH = 6,
    parameter int RANGE = 40
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             write_Enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic [31:0]      out,
    output logic             valid,
    output logic             busy,
    output logic             lock_fix
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period_cnt,
    output logic             period_wrap
`endif
);

    generate
        if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
            $error("lfsr_range_gen: WIDTH must be in 3..16");
        end
    endgenerate

    // Maximal-length XNOR tap masks, bit n-1 set for 1-indexed tap n.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16  = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAPS16[WIDTH-1:0];
    localparam bit               NO_RED  = (RANGE <= 0) || (RANGE >= (1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0] RANGE_W = NO_RED ? '0 : WIDTH'(RANGE);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] r;
    logic             fb;
    logic [WIDTH-1:0] shifted;

    assign fb      = ~^(x & TAPS);
    assign shifted = {x[WIDTH-2:0], fb};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            x        <= '0;
            lock_fix <= 1'b0;
        end else begin
            lock_fix <= 1'b0;
            if (x == '1) begin
                x        <= '0;
                lock_fix <= 1'b1;
            end else if (seed_load) begin
                if (seed == '1) begin
                    x        <= '0;
                    lock_fix <= 1'b1;
                end else begin
                    x <= seed;
                end
            end else if (write_Enable) begin
                x <= shifted;
            end
        end
    end

    // r is a private copy of x, so LFSR stepping during REDUCE cannot disturb it.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
            r     <= '0;
            out   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (req) begin
                        r     <= x;
                        busy  <= 1'b1;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (!NO_RED && r >= RANGE_W) begin
                        r <= r - RANGE_W;
                    end else begin
                        out   <= {{(32-WIDTH){1'b0}}, r};
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] start;

    // start mirrors whatever x was (re)initialised to, so the wrap compare targets it.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            start       <= '0;
            period_cnt  <= '0;
            period_wrap <= 1'b0;
        end else begin
            period_wrap <= 1'b0;
            if (x == '1) begin
                start      <= '0;
                period_cnt <= '0;
            end else if (seed_load) begin
                start      <= (seed == '1) ? '0 : seed;
                period_cnt <= '0;
            end else if (write_Enable) begin
                if (shifted == start) begin
                    period_cnt  <= '0;
                    period_wrap <= 1'b1;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end
`else
    // Period tracking not built.
`endif

endmodule
